// File: rtl/xbus_pe_rx.sv
// xbus_pe_rx: PE-side receiver for the X bus (global buffer to PE traffic).
//
// Holds a programmable PE ID and compares it with the TAG of every bus word.
// Words addressed to this PE (or broadcast, TAG all-ones) are steered by type
// into one of three first-word-fall-through FIFOs (ifmap, filter, psum), each
// with its own valid/ready port towards the PE datapath. Back-pressure is only
// applied to words addressed to this PE.
//
// Ports:
//   clk, rstn                      clock, async active-low reset
//   cfg_id_we, cfg_id_in, pe_id    PE ID register load / current value
//   bus_valid, bus_tag, bus_type,
//   bus_data, bus_ready            X bus word and its ready
//   ifmap_valid/ready/data         ifmap FIFO output port
//   fltr_valid/ready/data          filter FIFO output port
//   psum_valid/ready/data          psum FIFO output port
//   rx_count                       accepted words, saturating
//   type_err                       sticky: matched reserved-type word seen

// Small FWFT FIFO. Full is taken from the registered count only, so a pop in
// the same cycle never opens a slot for a push.
module xbus_pe_rx_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    output logic             valid,
    input  logic             ready,
    output logic [WIDTH-1:0] data
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             pop;
    logic             do_push;

    assign valid   = (count != '0);
    assign full    = (count == FULL_CNT);
    assign pop     = valid & ready;
    assign do_push = push & ~full;
    assign data    = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module xbus_pe_rx #(
    parameter int DATA_WIDTH = 16,
    parameter int ID_WIDTH   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    cfg_id_we,
    input  logic [ID_WIDTH-1:0]     cfg_id_in,
    output logic [ID_WIDTH-1:0]     pe_id,
    input  logic                    bus_valid,
    input  logic [ID_WIDTH-1:0]     bus_tag,
    input  logic [1:0]              bus_type,
    input  logic [2*DATA_WIDTH-1:0] bus_data,
    output logic                    bus_ready,
    output logic                    ifmap_valid,
    input  logic                    ifmap_ready,
    output logic [DATA_WIDTH-1:0]   ifmap_data,
    output logic                    fltr_valid,
    input  logic                    fltr_ready,
    output logic [DATA_WIDTH-1:0]   fltr_data,
    output logic                    psum_valid,
    input  logic                    psum_ready,
    output logic [2*DATA_WIDTH-1:0] psum_data,
    output logic [15:0]             rx_count,
    output logic                    type_err
);
    localparam logic [1:0] TYPE_IFMAP = 2'd0;
    localparam logic [1:0] TYPE_FLTR  = 2'd1;
    localparam logic [1:0] TYPE_PSUM  = 2'd2;
    localparam logic [1:0] TYPE_RSVD  = 2'd3;

    logic match;
    logic sel_full;
    logic accept;
    logic drop_rsvd;
    logic ifmap_full;
    logic fltr_full;
    logic psum_full;

    // Matching always uses the registered ID, so an ID write in the same
    // cycle as a bus word only affects later words.
    assign match = (bus_tag == pe_id) || (bus_tag == {ID_WIDTH{1'b1}});

    always_comb begin
        sel_full = 1'b0;
        case (bus_type)
            TYPE_IFMAP: sel_full = ifmap_full;
            TYPE_FLTR:  sel_full = fltr_full;
            TYPE_PSUM:  sel_full = psum_full;
            default:    sel_full = 1'b0;
        endcase
    end

    // Unaddressed and reserved-type words are always taken so they never
    // stall the bus.
    assign bus_ready = ~match | (bus_type == TYPE_RSVD) | ~sel_full;
    assign accept    = bus_valid & bus_ready & match & (bus_type != TYPE_RSVD);
    assign drop_rsvd = bus_valid & match & (bus_type == TYPE_RSVD);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pe_id    <= '0;
            rx_count <= '0;
            type_err <= 1'b0;
        end else begin
            if (cfg_id_we) begin
                pe_id <= cfg_id_in;
            end
            if (accept && rx_count != 16'hFFFF) begin
                rx_count <= rx_count + 16'd1;
            end
            if (drop_rsvd) begin
                type_err <= 1'b1;
            end
        end
    end

    xbus_pe_rx_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_ifmap_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (accept && bus_type == TYPE_IFMAP),
        .push_data (bus_data[DATA_WIDTH-1:0]),
        .full      (ifmap_full),
        .valid     (ifmap_valid),
        .ready     (ifmap_ready),
        .data      (ifmap_data)
    );

    xbus_pe_rx_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fltr_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (accept && bus_type == TYPE_FLTR),
        .push_data (bus_data[DATA_WIDTH-1:0]),
        .full      (fltr_full),
        .valid     (fltr_valid),
        .ready     (fltr_ready),
        .data      (fltr_data)
    );

    xbus_pe_rx_fifo #(.WIDTH(2*DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_psum_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (accept && bus_type == TYPE_PSUM),
        .push_data (bus_data),
        .full      (psum_full),
        .valid     (psum_valid),
        .ready     (psum_ready),
        .data      (psum_data)
    );
endmodule

// File: tb/tb_xbus_pe_rx.sv
// Testbench for xbus_pe_rx: directed scenarios plus randomized traffic,
// checked by a queue-based reference model and a separate output monitor.
module tb_xbus_pe_rx;
    localparam int DW    = 16;
    localparam int IW    = 4;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          cfg_id_we = 1'b0;
    logic [IW-1:0] cfg_id_in = '0;
    logic [IW-1:0] pe_id;
    logic          bus_valid = 1'b0;
    logic [IW-1:0] bus_tag = '0;
    logic [1:0]    bus_type = '0;
    logic [31:0]   bus_data = '0;
    logic          bus_ready;
    logic          ifmap_valid, fltr_valid, psum_valid;
    logic          ifmap_ready = 1'b0, fltr_ready = 1'b0, psum_ready = 1'b0;
    logic [DW-1:0] ifmap_data, fltr_data;
    logic [31:0]   psum_data;
    logic [15:0]   rx_count;
    logic          type_err;

    xbus_pe_rx #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn),
        .cfg_id_we(cfg_id_we), .cfg_id_in(cfg_id_in), .pe_id(pe_id),
        .bus_valid(bus_valid), .bus_tag(bus_tag), .bus_type(bus_type),
        .bus_data(bus_data), .bus_ready(bus_ready),
        .ifmap_valid(ifmap_valid), .ifmap_ready(ifmap_ready), .ifmap_data(ifmap_data),
        .fltr_valid(fltr_valid), .fltr_ready(fltr_ready), .fltr_data(fltr_data),
        .psum_valid(psum_valid), .psum_ready(psum_ready), .psum_data(psum_data),
        .rx_count(rx_count), .type_err(type_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: one queue of expected words per type, plus counters.
    logic [31:0]   q_if[$];
    logic [31:0]   q_fl[$];
    logic [31:0]   q_ps[$];
    int            m_rxc  = 0;
    logic          m_terr = 1'b0;
    logic [IW-1:0] m_id   = '0;
    // Effects predicted for the coming edge, applied just after it.
    logic          p_push = 1'b0;
    logic [1:0]    p_type = '0;
    logic [31:0]   p_data = '0;
    logic          p_err  = 1'b0;
    logic          p_we   = 1'b0;
    logic [IW-1:0] p_id   = '0;
    logic          mon_en = 1'b0;
    // Ready levels applied by the driver on the next step.
    logic          r_if = 1'b0, r_fl = 1'b0, r_ps = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int qsize(input logic [1:0] t);
        case (t)
            2'd0:    return q_if.size();
            2'd1:    return q_fl.size();
            2'd2:    return q_ps.size();
            default: return 0;
        endcase
    endfunction

    function automatic logic model_ready(input logic [IW-1:0] tag, input logic [1:0] ty);
        if (!(tag == m_id || tag == 4'hF)) return 1'b1;
        if (ty == 2'd3) return 1'b1;
        return qsize(ty) < DEPTH;
    endfunction

    task automatic commit();
        if (p_push) begin
            case (p_type)
                2'd0:    q_if.push_back({16'h0, p_data[15:0]});
                2'd1:    q_fl.push_back({16'h0, p_data[15:0]});
                default: q_ps.push_back(p_data);
            endcase
            if (m_rxc < 65535) m_rxc++;
        end
        if (p_err) m_terr = 1'b1;
        if (p_we) m_id = p_id;
        p_push = 1'b0;
        p_err  = 1'b0;
        p_we   = 1'b0;
    endtask

    task automatic model_reset();
        q_if.delete();
        q_fl.delete();
        q_ps.delete();
        m_rxc  = 0;
        m_terr = 1'b0;
        m_id   = '0;
        p_push = 1'b0;
        p_err  = 1'b0;
        p_we   = 1'b0;
    endtask

    // One bus cycle: drive just after the edge, then predict and check
    // bus_ready. taken = word consumed by the bus handshake.
    task automatic step(input logic v, input logic [IW-1:0] tag, input logic [1:0] ty,
                        input logic [31:0] d, input logic we, input logic [IW-1:0] idin,
                        output logic taken);
        logic er;
        logic m;
        @(posedge clk);
        #1;
        commit();
        bus_valid   = v;
        bus_tag     = tag;
        bus_type    = ty;
        bus_data    = d;
        cfg_id_we   = we;
        cfg_id_in   = idin;
        ifmap_ready = r_if;
        fltr_ready  = r_fl;
        psum_ready  = r_ps;
        #1;
        er = model_ready(tag, ty);
        m  = (tag == m_id) || (tag == 4'hF);
        chk("bus_ready", {31'h0, bus_ready}, {31'h0, er});
        p_push = v & er & m & (ty != 2'd3);
        p_type = ty;
        p_data = d;
        p_err  = v & m & (ty == 2'd3);
        p_we   = we;
        p_id   = idin;
        taken  = v & er;
    endtask

    task automatic idle();
        logic t;
        step(1'b0, '0, 2'd0, 32'h0, 1'b0, '0, t);
    endtask

    task automatic send(input logic [IW-1:0] tag, input logic [1:0] ty, input logic [31:0] d);
        logic t;
        t = 1'b0;
        for (int i = 0; i < 40 && !t; i++) step(1'b1, tag, ty, d, 1'b0, '0, t);
        if (!t) chk("send_timeout", 32'h0, 32'h1);
    endtask

    task automatic set_id(input logic [IW-1:0] id);
        logic t;
        step(1'b0, '0, 2'd0, 32'h0, 1'b1, id, t);
    endtask

    // Monitor: mid-cycle, compare each port with the head of its queue and
    // retire the entry when the handshake will complete at the next edge.
    always @(negedge clk) begin
        if (mon_en && rstn) begin
            chk("ifmap_valid", {31'h0, ifmap_valid}, {31'h0, q_if.size() != 0});
            if (q_if.size() != 0) begin
                chk("ifmap_data", {16'h0, ifmap_data}, q_if[0]);
                if (ifmap_ready) void'(q_if.pop_front());
            end else chk("ifmap_data_idle", {16'h0, ifmap_data}, 32'h0);
            chk("fltr_valid", {31'h0, fltr_valid}, {31'h0, q_fl.size() != 0});
            if (q_fl.size() != 0) begin
                chk("fltr_data", {16'h0, fltr_data}, q_fl[0]);
                if (fltr_ready) void'(q_fl.pop_front());
            end else chk("fltr_data_idle", {16'h0, fltr_data}, 32'h0);
            chk("psum_valid", {31'h0, psum_valid}, {31'h0, q_ps.size() != 0});
            if (q_ps.size() != 0) begin
                chk("psum_data", psum_data, q_ps[0]);
                if (psum_ready) void'(q_ps.pop_front());
            end else chk("psum_data_idle", psum_data, 32'h0);
            chk("rx_count", {16'h0, rx_count}, m_rxc[31:0]);
            chk("type_err", {31'h0, type_err}, {31'h0, m_terr});
            chk("pe_id", {28'h0, pe_id}, {28'h0, m_id});
        end
    end

    initial begin
        logic t;
        logic [IW-1:0] tag;
        logic [1:0] ty;

        // Reset state, checked while reset is held.
        bus_valid = 1'b1;
        bus_tag   = 4'h0;
        bus_type  = 2'd0;
        #12;
        chk("rst_pe_id", {28'h0, pe_id}, 32'h0);
        chk("rst_rx_count", {16'h0, rx_count}, 32'h0);
        chk("rst_type_err", {31'h0, type_err}, 32'h0);
        chk("rst_valids", {29'h0, ifmap_valid, fltr_valid, psum_valid}, 32'h0);
        chk("rst_data", {16'h0, ifmap_data | fltr_data}, 32'h0);
        chk("rst_psum_data", psum_data, 32'h0);
        chk("rst_bus_ready", {31'h0, bus_ready}, 32'h1);
        bus_valid = 1'b0;
        @(posedge clk);
        #1;
        rstn   = 1'b1;
        mon_en = 1'b1;

        // Addressed ifmap word is buffered while the PE is not ready.
        set_id(4'd5);
        send(4'd5, 2'd0, 32'hABCD_1234);
        idle();
        chk("ifmap_first_valid", {31'h0, ifmap_valid}, 32'h1);
        chk("ifmap_first_data", {16'h0, ifmap_data}, 32'h1234);
        chk("ifmap_first_count", {16'h0, rx_count}, 32'h1);

        // Foreign TAG ignored, broadcast TAG captured.
        step(1'b1, 4'd3, 2'd1, 32'h0000_5555, 1'b0, '0, t);
        chk("foreign_taken", {31'h0, t}, 32'h1);
        send(4'hF, 2'd1, 32'h0000_BEEF);
        idle();
        chk("bcast_fltr_data", {16'h0, fltr_data}, 32'hBEEF);

        // psum FIFO fills at 4, 5th word stalls, and a pop does not free a
        // slot in the same cycle.
        for (int i = 1; i <= 4; i++) send(4'd5, 2'd2, i);
        step(1'b1, 4'd5, 2'd2, 32'h5, 1'b0, '0, t);
        chk("psum_full_stall", {31'h0, t}, 32'h0);
        r_ps = 1'b1;
        step(1'b1, 4'd5, 2'd2, 32'h5, 1'b0, '0, t);
        chk("psum_pop_cycle_stall", {31'h0, t}, 32'h0);
        step(1'b1, 4'd5, 2'd2, 32'h5, 1'b0, '0, t);
        chk("psum_after_pop_accept", {31'h0, t}, 32'h1);
        repeat (6) idle();
        r_ps = 1'b0;

        // Drain ifmap/fltr, then hold 2 ifmap entries and stream push+pop.
        r_if = 1'b1;
        r_fl = 1'b1;
        repeat (3) idle();
        r_if = 1'b0;
        send(4'd5, 2'd0, 32'h0000_0A01);
        send(4'd5, 2'd0, 32'h0000_0A02);
        r_if = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 4'd5, 2'd0, $urandom, 1'b0, '0, t);
            chk("stream_accept", {31'h0, t}, 32'h1);
        end
        repeat (4) idle();

        // Reserved type: consumed, nothing buffered, sticky error.
        step(1'b1, 4'd5, 2'd3, 32'h0000_DEAD, 1'b0, '0, t);
        chk("rsvd_taken", {31'h0, t}, 32'h1);
        idle();
        chk("rsvd_type_err", {31'h0, type_err}, 32'h1);
        chk("rsvd_no_ifmap", {31'h0, ifmap_valid}, 32'h0);

        // Randomized traffic with random back-pressure and ID changes.
        for (int i = 0; i < 400; i++) begin
            r_if = ($urandom_range(0, 2) != 0);
            r_fl = ($urandom_range(0, 3) == 0);
            r_ps = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 3))
                0:       tag = m_id;
                1:       tag = 4'hF;
                2:       tag = m_id;
                default: tag = 4'($urandom);
            endcase
            ty = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            step($urandom_range(0, 9) < 7, tag, ty, $urandom,
                 $urandom_range(0, 29) == 0, 4'($urandom), t);
        end

        // Mid-transfer reset between edges clears everything at once.
        r_if = 1'b0;
        r_fl = 1'b1;
        r_ps = 1'b1;
        set_id(4'd9);
        repeat (6) idle();
        r_fl = 1'b0;
        r_ps = 1'b0;
        r_if = 1'b1;
        repeat (6) idle();
        r_if = 1'b0;
        for (int i = 0; i < 3; i++) send(4'd9, 2'd0, 32'h100 + i);
        idle();
        chk("pre_rst_ifmap_valid", {31'h0, ifmap_valid}, 32'h1);
        @(posedge clk);
        #1;
        commit();
        #2;
        mon_en = 1'b0;
        rstn   = 1'b0;
        #1;
        chk("async_rst_valids", {29'h0, ifmap_valid, fltr_valid, psum_valid}, 32'h0);
        chk("async_rst_rx_count", {16'h0, rx_count}, 32'h0);
        chk("async_rst_ifmap_data", {16'h0, ifmap_data}, 32'h0);
        chk("async_rst_type_err", {31'h0, type_err}, 32'h0);
        rstn = 1'b1;
        model_reset();
        mon_en = 1'b1;

        // Traffic resumes normally after reset.
        send(4'd0, 2'd2, 32'hCAFE_F00D);
        r_ps = 1'b1;
        repeat (4) idle();
        chk("post_rst_count", {16'h0, rx_count}, 32'h1);

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
